seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
- Iterative signed integer divider. It is the inverse-operation companion to the team's sequential radix-4 Booth multiplier and shares the same operand widths and the `clk`/`reset`/`en` style.
- Produces one quotient bit per active cycle using a restoring algorithm on operand magnitudes, followed by a sign-fixup cycle.
- Sits in the arithmetic unit next to the multiplier. Uses a start/busy/done handshake so a controller can issue one division at a time.

Parameters:
N, 32, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low; 0 forces idle state and clears all registers immediately
en  input  1  clock enable; 0 freezes iteration counter, datapath and FSM (except done clearing)
start  input  1  request a division; sampled only in IDLE with en=1
dividend  input  N  signed two's-complement dividend, sampled with accepted start
divisor  input  N  signed two's-complement divisor, sampled with accepted start
quotient  output  N  signed quotient, truncated toward zero
remainder  output  N  signed remainder; sign equals dividend sign, or 0
busy  output  1  1 while in CALC or FIX
done  output  1  single-cycle pulse when quotient/remainder are updated
div_by_zero  output  1  registered flag for the last completed operation; 1 when its divisor was 0

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - quotient, remainder, busy, done and div_by_zero all go to 0.
  - Internal magnitude registers, sign flags and iteration counter go to 0.
  - Reset in mid-operation abandons that operation. No done is produced for it.
- States and transitions:
  - IDLE: busy=0. On a rising edge with en=1 and start=1, the operation is accepted.
    - Divisor != 0: latch |dividend| into the partial-quotient register, |divisor| into the divisor register, zero the N+1-bit partial remainder, store sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), set counter=0, go to CALC.
    - Divisor == 0: stay in IDLE. On the same edge set quotient = all ones (-1), remainder = dividend, div_by_zero = 1, done = 1.
  - CALC: each edge with en=1 does one step:
    - Shift {partial remainder, partial quotient} left by 1.
    - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set quotient LSB = 1; otherwise restore and set quotient LSB = 0.
    - Increment the counter. After step N (counter reaches N), go to FIX.
  - FIX: on the edge with en=1:
    - quotient = sign_q ? -mag_q : mag_q.
    - remainder = sign_r ? -mag_r : mag_r.
    - Set div_by_zero=0 and done=1, return to IDLE.
- Magnitudes are computed as N-bit unsigned values, so |MIN| = 2^(N-1) is representable. Negation wraps modulo 2^N.
- Overflow case MIN / -1: quotient = MIN (0x80000000 for N=32), remainder = 0. No flag is raised.
- Latency: start accepted at edge E0 → done=1 and results valid after edge E0+N+1, counting only en=1 edges. With en=1 throughout, this is 33 cycles for N=32. Divide-by-zero completes after E0 (1 cycle).
- done is high for exactly one cycle. It is cleared on the next rising edge regardless of en.
- Accepting a new start in the cycle done is high is legal; done clears on that edge.
- start while busy=1 is ignored: no queueing, the current operation is unaffected.
- quotient, remainder and div_by_zero hold their last values until the next done. They are not disturbed during CALC.
- en=0 during CALC or FIX stalls the operation with no state change. Resuming en continues without loss.
- Inputs dividend and divisor are don't-care after the accept edge.

Test Plan:
- Basic positive: dividend=100, divisor=7, start pulse, en=1 → after 33 cycles done=1, quotient=14, remainder=2, div_by_zero=0, busy low after done.
- Signs: -100/7 → q=-14, r=-2; 100/-7 → q=-14, r=2; -100/-7 → q=14, r=-2.
- Boundaries:
  - 0x80000000 / -1 → q=0x80000000, r=0.
  - 0x80000000 / 1 → q=0x80000000, r=0.
  - 5/9 → q=0, r=5.
  - 0x7FFFFFFF / 0x7FFFFFFF → q=1, r=0.
- Divide-by-zero: 1234/0 → done one cycle after accept, q=0xFFFFFFFF, r=1234, div_by_zero=1. A following 10/3 → q=3, r=1, div_by_zero=0.
- Handshake/stall:
  - Second start asserted mid-CALC is ignored; first result is correct and arrives on time.
  - en=0 for 5 cycles mid-CALC delays done by exactly 5 cycles with identical result.
  - Back-to-back start in the done cycle is accepted.
- Reset: drive reset=0 asynchronously mid-CALC (between edges) → outputs and busy are 0 immediately, no done follows. A new division after release (e.g. 50/5) completes correctly with q=10, r=0.

Source files
------------

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: iterative restoring signed divider, one quotient bit per enabled cycle plus a sign-fixup cycle
// Ports: clk, reset (async active-low), en (clock enable), start/dividend/divisor (request),
//        quotient/remainder (signed results), busy, done (1-cycle pulse), div_by_zero (last op had divisor 0)
module seq_signed_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [N:0]    shifted, trial;
    // The partial remainder always stays below the divisor magnitude (<= 2^(N-1)),
    // so N stored bits suffice; only the shifted trial value needs the extra bit.
    always_comb begin
        shifted     = {rem_q, quo_q[N-1]};
        trial       = shifted - {1'b0, dvs_q};
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start && divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else if (start) begin
                        quo_d     = dividend[N-1] ? -dividend : dividend;
                        dvs_d     = divisor[N-1] ? -divisor : divisor;
                        rem_d     = '0;
                        neg_quo_d = dividend[N-1] ^ divisor[N-1];
                        neg_rem_d = dividend[N-1];
                        cnt_d     = '0;
                        state_d   = CALC;
                    end
                end
                CALC: begin
                    rem_d   = trial[N] ? shifted[N-1:0] : trial[N-1:0];
                    quo_d   = {quo_q[N-2:0], ~trial[N]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(N - 1)) ? FIX : CALC;
                end
                FIX: begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed self-checking bench for seq_signed_divider (N=32)
module tb_seq_signed_divider;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient, remainder;
    logic        busy, done, div_by_zero;
    int          vectors = 0;
    int          miscompares = 0;
    int          lat;
    int          seen_done;

    seq_signed_divider #(.N(32)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        issue(a, b);
    endtask

    // lat counts enabled-or-not edges after the accept edge
    task automatic wait_done(input int lat0, output int l);
        l = lat0;
        while (done !== 1'b1 && l < 200) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic check_res(input string tag, input int l, input int el,
                             input logic [31:0] eq, input logic [31:0] er, input logic ed);
        chk({tag, "_lat"}, 32'(l), 32'(el));
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ed});
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
        int l;
        start_op(a, b);
        wait_done(0, l);
        check_res(tag, l, 33, eq, er, 1'b0);
    endtask

    initial begin
        #1;
        chk("rst_q", quotient, 32'h0);
        chk("rst_r", remainder, 32'h0);
        chk("rst_flags", {29'b0, busy, done, div_by_zero}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        start_op(32'd100, 32'd7);
        chk("basic_busy", {31'b0, busy}, 32'h1);
        wait_done(0, lat);
        check_res("basic", lat, 33, 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        chk("basic_done_pulse", {31'b0, done}, 32'h0);
        chk("basic_busy_after", {31'b0, busy}, 32'h0);
        run("neg_pos", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
        run("pos_neg", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
        run("neg_neg", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);
        run("min_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
        run("min_1", 32'h80000000, 32'd1, 32'h80000000, 32'h0);
        run("small", 32'd5, 32'd9, 32'd0, 32'd5);
        run("max_max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd0);
        run("m7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        start_op(32'd1234, 32'd0);
        wait_done(0, lat);
        check_res("dbz", lat, 0, 32'hFFFFFFFF, 32'd1234, 1'b1);
        chk("dbz_busy", {31'b0, busy}, 32'h0);
        run("after_dbz", 32'd10, 32'd3, 32'd3, 32'd1);
        start_op(32'd100, 32'd7);
        repeat (5) @(negedge clk);
        issue(32'd1, 32'd1);
        chk("ign_hold_q", quotient, 32'd3);
        wait_done(6, lat);
        check_res("ignored_start", lat, 33, 32'd14, 32'd2, 1'b0);
        start_op(32'hFFFFFF9C, 32'd7);
        repeat (9) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_busy", {31'b0, busy}, 32'h1);
        chk("stall_hold_q", quotient, 32'd14);
        en = 1'b1;
        wait_done(14, lat);
        check_res("stall", lat, 38, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        issue(32'd50, 32'hFFFFFFFB);
        chk("b2b_done_clear", {31'b0, done}, 32'h0);
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        wait_done(0, lat);
        check_res("b2b", lat, 33, 32'hFFFFFFF6, 32'd0, 1'b0);
        start_op(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_q", quotient, 32'h0);
        chk("arst_r", remainder, 32'h0);
        chk("arst_flags", {29'b0, busy, done, div_by_zero}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        chk("arst_no_done", 32'(seen_done), 32'h0);
        run("post_rst", 32'd50, 32'd5, 32'd10, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
